mips_cpu_divider: RTL

Multi-cycle iterative divider for the MIPS DIV/DIVU instructions. It is the inverse arithmetic unit to the combinational multiplier.
- Takes a 32-bit dividend and divisor, signed or unsigned.
- Produces quotient (for LO) and remainder (for HI) after a fixed latency, using a restoring shift-subtract datapath.
- Sits beside the multiplier in the execute stage. The CPU stalls on busy and writes HI/LO on done.

---
 rtl/mips_cpu_divider.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mips_cpu_divider.sv
// mips_cpu_divider: multi-cycle restoring divider for MIPS DIV/DIVU.
// Works on operand magnitudes, producing one quotient bit per clock, and
// applies the sign fix-up in a final cycle. Quotient goes to LO and
// remainder goes to HI.
module mips_cpu_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CALC   = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    // Conditional two's-complement negate, used for both magnitude and sign fix.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic en);
        logic [WIDTH-1:0] res;
        if (en) begin
            res = (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            res = v;
        end
        return res;
    endfunction

    logic [1:0]       state_r;
    logic [CW-1:0]    count_r;
    logic             neg_q_r;
    logic             neg_r_r;
    logic [WIDTH-1:0] dvs_r;      // divisor magnitude
    logic [WIDTH-1:0] dvd_r;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] rem_r;      // partial remainder
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             div_zero_r;

    // The trial subtraction is one bit wider than the operands, so a
    // magnitude of 2^(WIDTH-1) or a divisor near 2^WIDTH never overflows.
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   trial_s;
    logic [WIDTH-1:0] rem_next_s;
    logic [WIDTH-1:0] dvd_next_s;

    assign shifted_s = {rem_r, dvd_r[WIDTH-1]};
    assign trial_s   = shifted_s - {1'b0, dvs_r};

    // One restoring step: keep the trial difference when it is non-negative.
    always_comb begin
        rem_next_s = shifted_s[WIDTH-1:0];
        dvd_next_s = {dvd_r[WIDTH-2:0], 1'b0};
        if (!trial_s[WIDTH]) begin
            rem_next_s    = trial_s[WIDTH-1:0];
            dvd_next_s[0] = 1'b1;
        end else begin
            rem_next_s    = shifted_s[WIDTH-1:0];
            dvd_next_s[0] = 1'b0;
        end
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            count_r     <= {CW{1'b0}};
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
            dvs_r       <= {WIDTH{1'b0}};
            dvd_r       <= {WIDTH{1'b0}};
            rem_r       <= {WIDTH{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
            div_zero_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        neg_q_r <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r_r <= sign & a[WIDTH-1];
                        dvd_r   <= cond_neg(a, sign & a[WIDTH-1]);
                        dvs_r   <= cond_neg(b, sign & b[WIDTH-1]);
                        rem_r   <= {WIDTH{1'b0}};
                        count_r <= {CW{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= CALC;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CALC: begin
                    rem_r   <= rem_next_s;
                    dvd_r   <= dvd_next_s;
                    count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                    if (count_r == LAST_CNT) begin
                        state_r <= FINISH;
                    end else begin
                        state_r <= CALC;
                    end
                end
                FINISH: begin
                    quotient_r  <= cond_neg(dvd_r, neg_q_r);
                    remainder_r <= cond_neg(rem_r, neg_r_r);
                    div_zero_r  <= (dvs_r == {WIDTH{1'b0}});
                    done_r      <= 1'b1;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign quotient  = quotient_r;
    assign remainder = remainder_r;
    assign div_zero  = div_zero_r;

endmodule
